// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo-core constants: result/tag widths, CDB layout and the
// functional-unit indices used on the common data bus request vector.
package tomasulo_pkg;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CDB_W  = 1 + TAG_W + DATA_W;

  // Tag value meaning "no producer"; never legal on a broadcast.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  // Requester slots on the CDB arbiter.
  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_LS  = 2'd3
  } fu_idx_e;

  // Bit positions inside the registered CDB word.
  localparam int unsigned CDB_VALID  = TAG_W + DATA_W;
  localparam int unsigned CDB_TAG_HI = TAG_W + DATA_W - 1;
  localparam int unsigned CDB_TAG_LO = DATA_W;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: scans req starting at index ptr, wrapping modulo N_REQ,
// and returns the first requester found. Purely combinational.
//   req    : request vector, bit i = requester i
//   ptr    : highest-priority index this cycle
//   grant  : one-hot winner (all zero when req is zero)
//   winner : binary index of the winner (0 when none)
//   found  : at least one request present
module rr_priority_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  always_comb begin
    int unsigned idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found              = 1'b1;
        winner             = IDX_W'(idx);
        grant[IDX_W'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common data bus arbiter. Functional units present tagged results with a
// request; one is accepted per cycle in round-robin order and broadcast on
// the registered CDB one cycle later.
//   clk       : core clock, posedge
//   rst       : asynchronous active-low reset
//   req       : per-FU request (0=ALU, 1=mul, 2=div, 3=ls)
//   req_data  : flattened results, slice i = {tag, value}, slice 0 in LSBs
//   grant     : one-hot combinational accept, consumed at the posedge
//   cdb       : registered {valid, tag, value}
//   bcast_cnt : number of valid broadcasts, wraps silently
//   tag0_err  : sticky, a granted request carried tag 0
module cdb_rr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W,
  parameter int unsigned DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*(TAG_W+DATA_W)-1:0] req_data,
  output logic [N_REQ-1:0]              grant,
  output logic [TAG_W+DATA_W:0]         cdb,
  output logic [15:0]                   bcast_cnt,
  output logic                          tag0_err
);

  import tomasulo_pkg::*;

  localparam int unsigned SLICE_W = TAG_W + DATA_W;
  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_winner;
  logic               pick_found;
  logic [SLICE_W-1:0] win_slice;
  logic [TAG_W-1:0]   win_tag;
  logic [IDX_W-1:0]   ptr_next;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .grant  (pick_grant),
    .winner (pick_winner),
    .found  (pick_found)
  );

  // Grant is masked during reset so no FU believes its result was consumed.
  assign grant = rst ? pick_grant : '0;

  always_comb begin
    win_slice = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) win_slice = req_data[i*SLICE_W +: SLICE_W];
    end
  end

  assign win_tag  = win_slice[SLICE_W-1:DATA_W];
  assign ptr_next = (32'(pick_winner) == N_REQ - 1) ? '0 : pick_winner + 1'b1;

  // A tag-0 request is still accepted (so the FU drains) but never broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      cdb       <= '0;
      bcast_cnt <= '0;
      tag0_err  <= 1'b0;
    end else if (pick_found) begin
      ptr <= ptr_next;
      if (win_tag != TAG_W'(NO_TAG)) begin
        cdb       <= {1'b1, win_slice};
        bcast_cnt <= bcast_cnt + 16'd1;
      end else begin
        cdb      <= '0;
        tag0_err <= 1'b1;
      end
    end else begin
      cdb <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
module tb_cdb_rr_arbiter;
  import tomasulo_pkg::*;

  localparam int N  = 4;
  localparam int SW = TAG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*SW-1:0]   req_data;
  logic [N-1:0]      grant;
  logic [CDB_W-1:0]  cdb;
  logic [15:0]       bcast_cnt;
  logic              tag0_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_rr_arbiter #(.N_REQ(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .cdb       (cdb),
    .bcast_cnt (bcast_cnt),
    .tag0_err  (tag0_err)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Fixed per-FU results for the directed sections.
  localparam logic [SW-1:0] D_ALU = 40'h05_0000_0011;
  localparam logic [SW-1:0] D_MUL = 40'h42_0000_00A6;
  localparam logic [SW-1:0] D_DIV = 40'h21_0000_0033;
  localparam logic [SW-1:0] D_LS  = 40'h7F_0000_0044;
  localparam logic [CDB_W-1:0] C_ALU = {1'b1, D_ALU};
  localparam logic [CDB_W-1:0] C_MUL = {1'b1, D_MUL};
  localparam logic [CDB_W-1:0] C_DIV = {1'b1, D_DIV};
  localparam logic [CDB_W-1:0] C_LS  = {1'b1, D_LS};

  typedef struct {
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [CDB_W-1:0] cdb;
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state for the random phase.
  int               m_ptr;
  int               m_cnt;
  bit               m_err;
  logic [CDB_W-1:0] m_cdb;
  bit               pend [N];
  logic [SW-1:0]    pdat [N];
  int               waitc [N];

  initial begin
    vec_t vecs [14];
    rst = 1'b0;
    req = '1;
    req_data = {D_LS, D_DIV, D_MUL, D_ALU};

    // Reset held with all requesting: nothing granted, bus and counter clear.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_cdb", 64'(cdb), 64'h0);
    chk("reset_cnt", 64'(bcast_cnt), 64'h0);
    chk("reset_err", 64'(tag0_err), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_reset_grant", 64'(grant), 64'h1);
    @(posedge clk); #1;
    chk("post_reset_cdb", 64'(cdb), 64'(C_ALU));

    // Sequential vector table, starting from ptr=0 after reset.
    vecs[0]  = '{4'b0011, 4'b0001, C_ALU};
    vecs[1]  = '{4'b0010, 4'b0010, C_MUL};
    vecs[2]  = '{4'b0000, 4'b0000, '0};
    vecs[3]  = '{4'b1111, 4'b0100, C_DIV};
    vecs[4]  = '{4'b1111, 4'b1000, C_LS};
    vecs[5]  = '{4'b1111, 4'b0001, C_ALU};
    vecs[6]  = '{4'b1111, 4'b0010, C_MUL};
    vecs[7]  = '{4'b1111, 4'b0100, C_DIV};
    vecs[8]  = '{4'b1111, 4'b1000, C_LS};
    vecs[9]  = '{4'b0001, 4'b0001, C_ALU};
    vecs[10] = '{4'b0001, 4'b0001, C_ALU};
    vecs[11] = '{4'b1001, 4'b1000, C_LS};
    vecs[12] = '{4'b1001, 4'b0001, C_ALU};
    vecs[13] = '{4'b0000, 4'b0000, '0};
    req = '0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      #1 chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].grant));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_cdb", i), 64'(cdb), 64'(vecs[i].cdb));
    end
    chk("vec_cnt", 64'(bcast_cnt), 64'd12);

    // Tag-0 from ls: granted, no broadcast, sticky error.
    @(negedge clk);
    req = 4'b1000;
    req_data = {40'h00_DEAD_BEEF, D_DIV, D_MUL, D_ALU};
    #1 chk("tag0_grant", 64'(grant), 64'h8);
    @(posedge clk); #1;
    chk("tag0_cdb", 64'(cdb), 64'h0);
    chk("tag0_err", 64'(tag0_err), 64'h1);
    chk("tag0_cnt", 64'(bcast_cnt), 64'd12);
    @(negedge clk);
    req = '0;
    req_data = {D_LS, D_DIV, D_MUL, D_ALU};
    @(posedge clk); #1;
    chk("tag0_sticky", 64'(tag0_err), 64'h1);

    // Async reset mid-cycle clears a valid bus before the next edge.
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("async_pre_cdb", 64'(cdb), 64'(C_ALU));
    #2 rst = 1'b0;
    #1;
    chk("async_cdb", 64'(cdb), 64'h0);
    chk("async_grant", 64'(grant), 64'h0);
    chk("async_err", 64'(tag0_err), 64'h0);
    chk("async_cnt", 64'(bcast_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    req = '0;

    // Counter wrap: 65535 broadcasts then one more.
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    repeat (65535) @(posedge clk);
    #1 chk("wrap_ffff", 64'(bcast_cnt), 64'hFFFF);
    @(posedge clk); #1;
    chk("wrap_zero", 64'(bcast_cnt), 64'h0);
    chk("wrap_cdb", 64'(cdb), 64'(C_ALU));
    chk("wrap_err", 64'(tag0_err), 64'h0);
    @(negedge clk);
    req = '0;

    // Random handshake-respecting traffic against a reference model.
    do_reset();
    m_ptr = 0; m_cnt = 0; m_err = 0; m_cdb = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; pdat[i] = '0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int win;
      logic [N-1:0] eg;
      logic [TAG_W-1:0] t;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          t = ($urandom_range(0, 15) == 0) ? '0 : TAG_W'($urandom_range(1, 255));
          pdat[i] = {t, DATA_W'($urandom)};
          pend[i] = 1;
          waitc[i] = 0;
        end
        req[i] = pend[i];
        req_data[i*SW +: SW] = pdat[i];
      end
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      #1 chk("rand_grant", 64'(grant), 64'(eg));
      @(posedge clk);
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (pdat[win][SW-1:DATA_W] != '0) begin
          m_cdb = {1'b1, pdat[win]};
          m_cnt = (m_cnt + 1) % 65536;
        end else begin
          m_cdb = '0;
          m_err = 1;
        end
        pend[win] = 0;
      end else begin
        m_cdb = '0;
      end
      for (int i = 0; i < N; i++) if (pend[i]) waitc[i]++;
      #1;
      chk("rand_cdb", 64'(cdb), 64'(m_cdb));
      chk("rand_cnt", 64'(bcast_cnt), 64'(m_cnt));
      chk("rand_err", 64'(tag0_err), 64'(m_err));
      for (int i = 0; i < N; i++) begin
        if (pend[i]) chk($sformatf("fair_wait%0d", i), 64'(waitc[i] < N), 64'h1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
Arbitrates functional-unit results onto the single common data bus of the Tomasulo core. The ALU, multiplier, divider and load/store units each present a tagged result (tag plus value) with a request. The arbiter uses round-robin priority with a valid/grant handshake and drives the registered broadcast consumed by taggedRegs and every reservation station. It sits directly downstream of unit_ALU's cdb_request/cdb_out pair and replaces fixed-priority bus selection.

Parameters:
N_REQ, 4, number of requesting FUs (index 0=ALU, 1=mul, 2=div, 3=ls)
TAG_W, 8, reservation-station tag width; tag 0 means "no producer"
DATA_W, 32, result value width

Ports:
clk  in  1  core clock, posedge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  N_REQ  per-FU broadcast request; bit i belongs to FU i
req_data  in  N_REQ*(TAG_W+DATA_W)  flattened FU results; slice i = {tag[TAG_W-1:0], value[DATA_W-1:0]}, i=0 in the LSBs
grant  out  N_REQ  one-hot combinational accept; FU i's result is consumed at the posedge where req[i]&grant[i]
cdb  out  1+TAG_W+DATA_W  registered bus: [40]=valid, [39:32]=tag, [31:0]=value
bcast_cnt  out  16  count of valid broadcasts, wraps at 16'hFFFF -> 0
tag0_err  out  1  sticky flag: a granted request carried tag 0

Behaviour:
- Reset (rst=0, async): cdb=0, ptr=0, bcast_cnt=0, tag0_err=0. grant is forced to 0 while rst=0.
- Pick, combinational each cycle: scan req from index ptr upward modulo N_REQ; the first set bit w wins. grant=onehot(w). If req==0, grant=0.
- Handshake: an FU holds req and req_data stable until it sees its grant bit high at a posedge, then drops req or presents its next result in the same edge. grant never asserts without the matching req bit.
- Broadcast latency is 1 cycle. At the posedge with grant[w]=1 and tag_w!=0: cdb <= {1'b1, tag_w, value_w}; bcast_cnt <= bcast_cnt+1.
- No grant at a posedge: cdb <= 0. valid drops and tag/value are cleared; the bus is never left holding stale data.
- Tag-0 request: it is still granted, so the FU drains and does not deadlock. No broadcast occurs (cdb <= 0), bcast_cnt is unchanged, and tag0_err <= 1. tag0_err is cleared only by reset.
- Pointer: after any grant to w, ptr <= (w+1) mod N_REQ. With no grant, ptr holds.
- Fairness: a continuously requesting FU is granted within N_REQ cycles. Back-to-back grants to the same FU occur only when no other FU requests.
- Simultaneous events: one grant per cycle at most; losers keep req asserted and are not dropped.
- Reset mid-operation: the in-flight cdb value is lost immediately (async clear). FUs must re-request after reset.
- bcast_cnt wrap: 16'hFFFF plus one broadcast gives 16'h0000, with no flag.

Decomposition:
- Shared package tomasulo_pkg: TAG_W, DATA_W, CDB_W=1+TAG_W+DATA_W, NO_TAG=0, FU index constants FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_LS=3, and CDB field offsets CDB_VALID=40, CDB_TAG_HI=39, CDB_TAG_LO=32.
- One sub-module, rr_priority_pick: req plus ptr in, one-hot grant plus winner index out, purely combinational. The top level holds the ptr, cdb, counter and error registers.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 -> grant=0, cdb=41'h0, bcast_cnt=0; release, then next posedge -> cdb valid with ALU data (ptr=0).
- Single requester: ALU req with 40'h05_0000_0011 for one cycle -> grant=4'b0001 that cycle; next cycle cdb=41'h1_05_0000_0011; following cycle cdb=0; bcast_cnt=1.
- Contention: ALU 40'h05_0000_0011 and mul 40'h42_0000_00A6 both requested from ptr=0 -> ALU granted first, then mul. cdb shows tag 05 then tag 42 on consecutive cycles; ptr ends at 2.
- Fairness: all four hold req for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,...; each FU broadcasts exactly twice.
- Tag-0: ls requests 40'h00_DEAD_BEEF -> grant=4'b1000; next cycle cdb valid=0, tag0_err=1, bcast_cnt unchanged.
- Wrap and async reset: preload by 65535 broadcasts, one more -> bcast_cnt=0. Drop rst mid-cycle while cdb valid -> cdb cleared before the next edge.
